// File: rtl/ps2_scancode_rx_if.sv
// Register-block side of the PS/2 scan-code receiver: FIFO head, occupancy,
// sticky error flags and the pop / clear strobes.
interface ps2_scancode_rx_if;
    logic       pop;
    logic       clear_err;
    logic [7:0] code_data;
    logic       code_break;
    logic       code_ext;
    logic       code_valid;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       frame_err;

    modport master (
        output pop, clear_err,
        input  code_data, code_break, code_ext, code_valid, fifo_count, overflow, frame_err
    );

    modport slave (
        input  pop, clear_err,
        output code_data, code_break, code_ext, code_valid, fifo_count, overflow, frame_err
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw lines, frames
// 11-bit packets, folds E0/F0 prefixes into flags and queues codes in a 4-deep FWFT FIFO.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_scancode_rx_if.slave  bus
);
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    function automatic logic odd_parity9(input logic [8:0] bits);
        return ^bits;
    endfunction

    logic             clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic             filt_r, filt_prev_r;
    logic [FLT_W-1:0] flt_cnt_r;
    logic             fall_s;

    state_t           state_r, state_s;
    logic [2:0]       bit_cnt_r, bit_cnt_s;
    logic [7:0]       shift_r, shift_s;
    logic             par_r, par_s;
    logic [TO_W-1:0]  to_cnt_r, to_cnt_s;
    logic             accept_s, discard_s;

    logic             ext_pend_r, brk_pend_r, push_r;
    logic [9:0]       push_data_r;

    logic [9:0]       mem_r [0:3];
    logic [1:0]       wr_ptr_r, rd_ptr_r;
    logic [2:0]       count_r;
    logic             overflow_r, frame_err_r;
    logic             do_pop_s, do_push_s, ovf_ev_s;

    // Two-flop synchronizers; idle bus level is high on both lines
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Clock deglitcher: level flips only after FILTER_LEN consecutive opposite samples
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            filt_r      <= 1'b1;
            filt_prev_r <= 1'b1;
            flt_cnt_r   <= FLT_W'(1'b0);
        end else begin
            filt_prev_r <= filt_r;
            if (clk_sync_r == filt_r) begin
                flt_cnt_r <= FLT_W'(1'b0);
            end else if (flt_cnt_r == FLT_W'(FILTER_LEN - 1)) begin
                filt_r    <= clk_sync_r;
                flt_cnt_r <= FLT_W'(1'b0);
            end else begin
                flt_cnt_r <= flt_cnt_r + FLT_W'(1'b1);
            end
        end
    end

    assign fall_s = filt_prev_r & ~filt_r;

    // Frame FSM state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
            to_cnt_r  <= TO_W'(1'b0);
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            par_r     <= par_s;
            to_cnt_r  <= to_cnt_s;
        end
    end

    // Frame FSM next state, bit capture and frame verdict
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        par_s     = par_r;
        to_cnt_s  = to_cnt_r;
        accept_s  = 1'b0;
        discard_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s && !data_sync_r) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_s) begin
                    shift_s   = {data_sync_r, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    state_s   = (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_s) begin
                    par_s   = data_sync_r;
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_s) begin
                    state_s = ST_IDLE;
                    if (data_sync_r && odd_parity9({par_r, shift_r})) begin
                        accept_s = 1'b1;
                    end else begin
                        discard_s = 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // A sample event always beats an expiring timeout on the same cycle
        if (state_r == ST_IDLE) begin
            to_cnt_s = TO_W'(1'b0);
        end else if (fall_s) begin
            to_cnt_s = TO_W'(1'b0);
        end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_s  = TO_W'(1'b0);
            state_s   = ST_IDLE;
            discard_s = 1'b1;
        end else begin
            to_cnt_s = to_cnt_r + TO_W'(1'b1);
        end
    end

    // Prefix tracking and one-cycle push staging
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
            push_r      <= 1'b0;
            push_data_r <= 10'h000;
        end else begin
            push_r <= 1'b0;
            if (discard_s) begin
                ext_pend_r <= 1'b0;
                brk_pend_r <= 1'b0;
            end else if (accept_s) begin
                if (shift_r == 8'hE0) begin
                    ext_pend_r <= 1'b1;
                end else if (shift_r == 8'hF0) begin
                    brk_pend_r <= 1'b1;
                end else begin
                    push_r      <= 1'b1;
                    push_data_r <= {ext_pend_r, brk_pend_r, shift_r};
                    ext_pend_r  <= 1'b0;
                    brk_pend_r  <= 1'b0;
                end
            end
        end
    end

    assign do_pop_s  = bus.pop & (count_r != 3'd0);
    assign do_push_s = push_r & ((count_r != 3'd4) | do_pop_s);
    assign ovf_ev_s  = push_r & (count_r == 3'd4) & ~do_pop_s;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 10'h000;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data_r;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; a new event in the clear cycle wins
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            overflow_r  <= ovf_ev_s  | (overflow_r  & ~bus.clear_err);
            frame_err_r <= discard_s | (frame_err_r & ~bus.clear_err);
        end
    end

    assign bus.code_data  = mem_r[rd_ptr_r][7:0];
    assign bus.code_break = mem_r[rd_ptr_r][8];
    assign bus.code_ext   = mem_r[rd_ptr_r][9];
    assign bus.code_valid = (count_r != 3'd0);
    assign bus.fifo_count = count_r;
    assign bus.overflow   = overflow_r;
    assign bus.frame_err  = frame_err_r;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: expected FIFO entries are queued as frames
// are sent and a negedge monitor compares the head on every consuming pop.
module tb_ps2_scancode_rx;
    localparam int FILT   = 4;
    localparam int TO_CYC = 200;
    localparam int HALF   = 10;

    logic ACLK = 1'b0;
    logic ARESET;
    logic ps2_clk;
    logic ps2_data;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic [9:0] exp_q [$];

    ps2_scancode_rx_if bus ();

    ps2_scancode_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every pop of a non-empty FIFO consumes one expected entry
    always @(negedge ACLK) begin
        if (!ARESET && bus.pop && bus.code_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: actual=0x%0h required=none",
                         {bus.code_ext, bus.code_break, bus.code_data});
            end else begin
                check("head_on_pop", {22'd0, bus.code_ext, bus.code_break, bus.code_data},
                      {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (3) tick();
        ps2_clk = 1'b0;
        repeat (HALF) tick();
        ps2_clk = 1'b1;
        repeat (HALF) tick();
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
    endtask

    // Full frame; the stop bit is clocked cycle by cycle to time latency and an optional pop
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_v,
                              input logic pop_at_stop, output int lat_o);
        send_partial(d, 8);
        send_bit((~^d) ^ bad_par);
        ps2_data = stop_v;
        repeat (3) tick();
        ps2_clk = 1'b0;
        lat_o = 0;
        for (int k = 1; k <= 2 * HALF; k++) begin
            @(posedge ACLK);
            #1;
            bus.pop = pop_at_stop && (k == FILT + 3);
            if (k == HALF) ps2_clk = 1'b1;
            @(negedge ACLK);
            if (lat_o == 0 && bus.code_valid) lat_o = k;
        end
        repeat (5) tick();
    endtask

    task automatic send(input logic [7:0] d);
        int unused_lat;
        send_frame(d, 1'b0, 1'b1, 1'b0, unused_lat);
    endtask

    task automatic do_pop();
        tick();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    task automatic do_clear();
        tick();
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge ACLK);
        check({tag, "_count"}, {29'd0, bus.fifo_count}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.code_valid}, 32'd0);
        check({tag, "_data"},  {24'd0, bus.code_data},  32'd0);
        check({tag, "_brk"},   {31'd0, bus.code_break}, 32'd0);
        check({tag, "_ext"},   {31'd0, bus.code_ext},   32'd0);
        check({tag, "_ovf"},   {31'd0, bus.overflow},   32'd0);
        check({tag, "_ferr"},  {31'd0, bus.frame_err},  32'd0);
    endtask

    function automatic logic [31:0] head();
        return {22'd0, bus.code_ext, bus.code_break, bus.code_data};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARESET = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        bus.pop = 1'b0;
        bus.clear_err = 1'b0;
        repeat (3) @(posedge ACLK);
        check_reset_outputs("por");
        tick();
        ARESET = 1'b0;
        repeat (5) tick();

        // Stray falling edge with data high while idle
        send_bit(1'b1);
        @(negedge ACLK);
        check("idle_high_count", {29'd0, bus.fifo_count}, 32'd0);
        check("idle_high_ferr",  {31'd0, bus.frame_err},  32'd0);

        // Plain make code, latency and empty pop
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, lat);
        check("latency_1c", lat, FILT + 4);
        @(negedge ACLK);
        check("count_1c", {29'd0, bus.fifo_count}, 32'd1);
        check("head_1c", head(), 32'h01C);
        do_pop();
        @(negedge ACLK);
        check("valid_after_pop", {31'd0, bus.code_valid}, 32'd0);
        do_pop();
        @(negedge ACLK);
        check("empty_pop_count", {29'd0, bus.fifo_count}, 32'd0);

        // Break and extended prefixes
        exp_q.push_back(10'h11C);
        send(8'hF0);
        send(8'h1C);
        @(negedge ACLK);
        check("count_f0_1c", {29'd0, bus.fifo_count}, 32'd1);
        check("head_f0_1c", head(), 32'h11C);
        do_pop();
        exp_q.push_back(10'h374);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        @(negedge ACLK);
        check("count_e0_f0_74", {29'd0, bus.fifo_count}, 32'd1);
        check("head_e0_f0_74", head(), 32'h374);
        do_pop();

        // Parity error after a prefix: flag set, prefix forgotten
        send(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, lat);
        @(negedge ACLK);
        check("bad_par_count", {29'd0, bus.fifo_count}, 32'd0);
        check("bad_par_ferr",  {31'd0, bus.frame_err},  32'd1);
        do_clear();
        @(negedge ACLK);
        check("clear_ferr", {31'd0, bus.frame_err}, 32'd0);
        exp_q.push_back(10'h01C);
        send(8'h1C);
        @(negedge ACLK);
        check("head_after_discard", head(), 32'h01C);
        do_pop();

        // Stop bit low
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, lat);
        @(negedge ACLK);
        check("bad_stop_count", {29'd0, bus.fifo_count}, 32'd0);
        check("bad_stop_ferr",  {31'd0, bus.frame_err},  32'd1);
        do_clear();

        // Overflow: fifth entry dropped
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(10'(i));
            send(8'(i));
        end
        @(negedge ACLK);
        check("full_count", {29'd0, bus.fifo_count}, 32'd4);
        check("full_ovf",   {31'd0, bus.overflow},   32'd1);
        check("full_head",  head(), 32'h001);
        for (int i = 0; i < 4; i++) do_pop();
        @(negedge ACLK);
        check("drained_count", {29'd0, bus.fifo_count}, 32'd0);
        check("ovf_sticky",    {31'd0, bus.overflow},   32'd1);
        do_clear();
        @(negedge ACLK);
        check("ovf_cleared", {31'd0, bus.overflow}, 32'd0);

        // Simultaneous push and pop while full
        for (int i = 6; i <= 9; i++) begin
            exp_q.push_back(10'(i));
            send(8'(i));
        end
        exp_q.push_back(10'h00A);
        send_frame(8'h0A, 1'b0, 1'b1, 1'b1, lat);
        @(negedge ACLK);
        check("full_pushpop_count", {29'd0, bus.fifo_count}, 32'd4);
        check("full_pushpop_ovf",   {31'd0, bus.overflow},   32'd0);
        for (int i = 0; i < 4; i++) do_pop();
        @(negedge ACLK);
        check("wrap_drained", {29'd0, bus.fifo_count}, 32'd0);

        // Timeout on a partial frame, then a clean frame
        send_partial(8'h0F, 4);
        repeat (TO_CYC + 20) tick();
        @(negedge ACLK);
        check("timeout_ferr",  {31'd0, bus.frame_err},  32'd1);
        check("timeout_count", {29'd0, bus.fifo_count}, 32'd0);
        exp_q.push_back(10'h029);
        send(8'h29);
        @(negedge ACLK);
        check("after_timeout_count", {29'd0, bus.fifo_count}, 32'd1);
        check("after_timeout_head",  head(), 32'h029);

        // Reset mid-frame with a queued entry and a raised flag
        send_partial(8'h00, 3);
        ARESET = 1'b1;
        tick();
        check_reset_outputs("midrst");
        exp_q.delete();
        tick();
        ARESET = 1'b0;
        repeat (5) tick();
        exp_q.push_back(10'h05A);
        send(8'h5A);
        @(negedge ACLK);
        check("after_rst_count", {29'd0, bus.fifo_count}, 32'd1);
        check("after_rst_head",  head(), 32'h05A);
        do_pop();
        @(negedge ACLK);
        check("final_count", {29'd0, bus.fifo_count}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
